fec_cc_encoder: RTL and testbench

- WiMAX forward-error-correction stage sitting directly downstream of the PRBS randomizer; consumes its serial randomized bit stream and feeds the interleaver.
- Implements the 802.16 rate-1/2, K=7 tail-biting convolutional code (G1=171o → X, G2=133o → Y).
- Tail-biting requires the last 6 bits of a block before encoding can start, so the block buffers one full block (BLOCK_BITS) and then emits one (X,Y) pair per input bit.

---
 rtl/fec_pkg.sv | 36 +++
 rtl/fec_block_buffer.sv | 54 +++++
 rtl/fec_cc_encoder.sv | 127 ++++++++++++
 tb/tb_fec_cc_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
// -----------------------------------------------------------------------------
// fec_pkg
// Shared definitions for the 802.16 rate-1/2, K=7 tail-biting convolutional
// encoder: generator polynomials, constraint length, the controller state
// type and the combinational (X,Y) pair function.
//
// Encoder state convention used throughout: s[0] is the delay-1 tap (most
// recently shifted bit), s[MEM-1] is the delay-6 tap (oldest bit).
// -----------------------------------------------------------------------------
package fec_pkg;

    localparam int K   = 7;
    localparam int MEM = K - 1;

    // Generator MSB corresponds to delay 0 (the current input bit u).
    localparam logic [K-1:0] G1 = 7'o171;   // -> X
    localparam logic [K-1:0] G2 = 7'o133;   // -> Y

    typedef enum logic {
        FILL   = 1'b0,
        ENCODE = 1'b1
    } fec_state_t;

    // Returns {X, Y} for input bit u and encoder state s.
    function automatic logic [1:0] conv_pair(input logic u, input logic [MEM-1:0] s);
        logic [K-1:0] window;
        // window[K-1-d] holds the bit at delay d, so it lines up with the
        // octal generator words directly.
        window[K-1] = u;
        for (int i = 0; i < MEM; i++) begin
            window[MEM-1-i] = s[i];
        end
        return {^(window & G1), ^(window & G2)};
    endfunction

endpackage

// File: rtl/fec_block_buffer.sv
// -----------------------------------------------------------------------------
// fec_block_buffer
// Single-block bit store for the tail-biting encoder. One bit is written per
// accepted input; any bit can be read combinationally by index; the last MEM
// bits of the block are exposed permanently for the encoder-state preload.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset (clears the store)
//   wr_en    in   write strobe
//   wr_idx   in   write bit index
//   wr_bit   in   bit to store
//   rd_idx   in   read bit index
//   rd_bit   out  bit at rd_idx
//   tail     out  tail[i] = bit (BLOCK_BITS-1-i), i = 0..MEM-1
// -----------------------------------------------------------------------------
module fec_block_buffer
    import fec_pkg::*;
#(
    parameter int BLOCK_BITS = 96,
    parameter int CNT_W      = $clog2(BLOCK_BITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic             wr_bit,
    input  logic [CNT_W-1:0] rd_idx,
    output logic             rd_bit,
    output logic [MEM-1:0]   tail
);

    logic [BLOCK_BITS-1:0] mem;

    // NOTE: this store is small and must come out of reset as all zeros, so it
    // lives in flops with an async clear rather than in a RAM macro (which
    // cannot be reset).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_bit;
        end
    end

    assign rd_bit = mem[rd_idx];

    always_comb begin
        for (int i = 0; i < MEM; i++) begin
            tail[i] = mem[BLOCK_BITS-1-i];
        end
    end

endmodule

// File: rtl/fec_cc_encoder.sv
// -----------------------------------------------------------------------------
// fec_cc_encoder
// 802.16 rate-1/2, K=7 tail-biting convolutional encoder (G1=171o -> X,
// G2=133o -> Y). Buffers one full block from the PRBS randomizer (FILL), then
// preloads the encoder with the last six block bits and emits one (X,Y) pair
// per buffered bit (ENCODE). Single buffer, no overlap between the two phases.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   data_in    in   randomized bit from the PRBS
//   valid_in   in   data_in valid
//   ready_fec  out  encoder accepts a bit this cycle (to PRBS)
//   data_out   out  coded pair, [1]=X (G1), [0]=Y (G2); 2'b00 when idle
//   valid_out  out  data_out valid
//   ready_in   in   interleaver accepts a pair this cycle
// -----------------------------------------------------------------------------
module fec_cc_encoder
    import fec_pkg::*;
#(
    parameter int BLOCK_BITS = 96,
    parameter int CNT_W      = $clog2(BLOCK_BITS)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       data_in,
    input  logic       valid_in,
    output logic       ready_fec,
    output logic [1:0] data_out,
    output logic       valid_out,
    input  logic       ready_in
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BITS - 1);

    fec_state_t       state;
    logic [CNT_W-1:0] count;
    logic [MEM-1:0]   enc_s;
    logic             run_q;     // holds ready_fec low until the first edge after reset

    logic             in_fire;
    logic             out_fire;
    logic             last_bit;
    logic             u_bit;
    logic [MEM-1:0]   tail;
    logic [MEM-1:0]   enc_s_next;

    assign ready_fec = run_q && (state == FILL);
    assign valid_out = (state == ENCODE);
    assign in_fire   = valid_in && ready_fec;
    assign out_fire  = valid_out && ready_in;
    assign last_bit  = (count == LAST_IDX);

    fec_block_buffer #(
        .BLOCK_BITS (BLOCK_BITS),
        .CNT_W      (CNT_W)
    ) u_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (in_fire),
        .wr_idx  (count),
        .wr_bit  (data_in),
        .rd_idx  (count),
        .rd_bit  (u_bit),
        .tail    (tail)
    );

    // Shift in u at the delay-1 end; oldest bit falls off s[MEM-1].
    assign enc_s_next = {enc_s[MEM-2:0], u_bit};

    // Output is purely a function of held registers, so it stays stable
    // across any number of stall cycles.
    assign data_out = valid_out ? conv_pair(u_bit, enc_s) : 2'b00;

    // NOTE: every register here is updated with <= so that all of them sample
    // the pre-edge values of each other; a blocking = would let later lines
    // see already-updated state within the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
            count <= '0;
            enc_s <= '0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                FILL: begin
                    if (in_fire) begin
                        if (last_bit) begin
                            state <= ENCODE;
                            count <= '0;
                            // Tail-biting preload: the newest block bit is
                            // still on data_in, the older five are in the buffer.
                            enc_s <= {tail[MEM-1:1], data_in};
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ENCODE: begin
                    if (out_fire) begin
                        enc_s <= enc_s_next;
                        if (last_bit) begin
                            state <= FILL;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    count <= '0;
                end
            endcase
        end
    end

    // Tail-biting invariant: after the final pair the encoder state is back
    // at the preload value, i.e. the last MEM bits of the block.
    always_ff @(posedge clk) begin
        if (reset_n && out_fire && last_bit) begin
            assert (enc_s_next == tail);
        end
    end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// -----------------------------------------------------------------------------
// tb_fec_cc_encoder
// Directed bench for fec_cc_encoder with BLOCK_BITS=96. Expected pairs come
// from hand-derived tables for all-zero, all-one and single-impulse blocks.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fec_cc_encoder;

    localparam int BB = 96;

    logic       clk;
    logic       reset_n;
    logic       data_in;
    logic       valid_in;
    logic       ready_fec;
    logic [1:0] data_out;
    logic       valid_out;
    logic       ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] pairs [BB];
    int         npairs;
    int         low_cnt;

    fec_cc_encoder #(.BLOCK_BITS(BB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_fec (ready_fec),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // kind: 0 all-zero, 1 all-one, 2 impulse at bit 0, 3 impulse at bit 95
    function automatic logic [1:0] expect_pair(input int kind, input int idx);
        logic [13:0] imp0_tab;
        logic [11:0] imp95_tab;
        imp0_tab  = 14'b11_10_11_11_00_01_11;
        imp95_tab = 12'b10_11_11_00_01_11;
        case (kind)
            0: return 2'b00;
            1: return 2'b11;
            2: return (idx < 7) ? imp0_tab[13-2*idx -: 2] : 2'b00;
            3: begin
                if (idx < 6)   return imp95_tab[11-2*idx -: 2];
                if (idx == 95) return 2'b11;
                return 2'b00;
            end
            default: return 2'bxx;
        endcase
    endfunction

    task automatic send_block(input logic [BB-1:0] blk, input bit gaps);
        int idx = 0;
        int cyc = 0;
        int vo_seen = 0;
        while (idx < BB && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (valid_out) vo_seen++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                data_in  = 1'($urandom_range(0, 1));
            end else if (ready_fec) begin
                valid_in = 1'b1;
                data_in  = blk[idx];
                idx++;
            end else begin
                valid_in = 1'b0;
            end
        end
        check("fill_bits_accepted", idx, BB);
        check("fill_no_valid_out", vo_seen, 0);
    endtask

    task automatic collect(input bit stall, input bit noise, input int stop_at);
        int         cyc = 0;
        logic       prev_stall = 1'b0;
        logic [1:0] prev = 2'b00;
        npairs  = 0;
        low_cnt = 0;
        while (npairs < stop_at && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("first_pair_latency", valid_out, 1);
            if (!ready_fec) low_cnt++;
            if (prev_stall) check("stall_hold", data_out, prev);
            ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                valid_in = 1'b1;
                data_in  = 1'($urandom_range(0, 1));
            end else begin
                valid_in = 1'b0;
            end
            if (valid_out && ready_in) begin
                pairs[npairs] = data_out;
                npairs++;
            end
            prev_stall = valid_out && !ready_in;
            prev       = data_out;
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
        check("pairs_collected", npairs, stop_at);
    endtask

    task automatic compare_block(input int kind, input string name);
        for (int i = 0; i < npairs; i++) begin
            check($sformatf("%s_pair%0d", name, i), pairs[i], expect_pair(kind, i));
        end
    endtask

    task automatic end_of_block(input string name);
        @(negedge clk);
        check({name, "_ready_back"}, ready_fec, 1);
        check({name, "_valid_low"}, valid_out, 0);
        check({name, "_data_zero"}, data_out, 0);
    endtask

    initial begin
        logic [BB-1:0] blk;

        reset_n  = 1'b0;
        data_in  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        #1;
        check("reset_ready_fec", ready_fec, 0);
        check("reset_valid_out", valid_out, 0);
        check("reset_data_out", data_out, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_ready_still_low", ready_fec, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", ready_fec, 1);
        check("fill_data_out_zero", data_out, 0);

        // All-zero block, no stalls: ready_fec low for exactly one block.
        send_block('0, 1'b0);
        collect(1'b0, 1'b0, BB);
        check("zero_ready_low_cycles", low_cnt, BB);
        compare_block(0, "zero");
        end_of_block("zero");

        // All-one block.
        send_block('1, 1'b0);
        collect(1'b0, 1'b0, BB);
        compare_block(1, "ones");
        end_of_block("ones");

        // Impulse at bit 0.
        blk = '0;
        blk[0] = 1'b1;
        send_block(blk, 1'b0);
        collect(1'b0, 1'b0, BB);
        compare_block(2, "imp0");
        end_of_block("imp0");

        // Impulse at bit 95 (tail-biting wrap into the first pairs).
        blk = '0;
        blk[BB-1] = 1'b1;
        send_block(blk, 1'b0);
        collect(1'b0, 1'b0, BB);
        compare_block(3, "imp95");
        end_of_block("imp95");

        // Impulse at bit 0 with input gaps, random back-pressure and
        // valid_in noise during ENCODE.
        blk = '0;
        blk[0] = 1'b1;
        send_block(blk, 1'b1);
        collect(1'b1, 1'b1, BB);
        compare_block(2, "bp");
        end_of_block("bp");

        // Reset in the middle of ENCODE, then a fresh all-one block.
        send_block(blk, 1'b0);
        collect(1'b0, 1'b0, 40);
        @(negedge clk);
        check("pre_reset_valid", valid_out, 1);
        reset_n = 1'b0;
        #1;
        check("midreset_valid_out", valid_out, 0);
        check("midreset_data_out", data_out, 0);
        check("midreset_ready_fec", ready_fec, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midreset_release_ready_low", ready_fec, 0);
        @(posedge clk);
        #1;
        check("midreset_ready_after_edge", ready_fec, 1);
        send_block('1, 1'b0);
        collect(1'b0, 1'b0, BB);
        compare_block(1, "post_reset_ones");
        end_of_block("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
